conv_job_arbiter: RTL and testbench
===================================

Name: conv_job_arbiter

Overview:
Round-robin scheduler sharing one fixed-length convolution engine between two requesters. Grants the engine to one requester per job and forwards that requester's L sample pairs into the engine with a valid/ready handshake. It then waits for the engine to finish and returns the 2L-1 results to the same requester, honouring backpressure. Sits between the two DSP clients and the convolution engine; one job is in flight at a time.

Parameters:
LEN, 8, convolution length L; number of sample pairs per job.
RES_CNT, 2*LEN-1, number of results drained per job; derived, never overridden.
TIMEOUT, 256, maximum cycles spent in WAIT before the job is aborted.

Ports:
clk  in  1  clock; all logic on rising edge.
reset  in  1  synchronous, active-low reset.
req  in  2  req[i]=1 requests a job for requester i; held until done[i] or err[i].
gnt  out  2  one-hot grant; gnt[i]=1 from GRANT through DONE of requester i's job.
s_valid  in  2  sample-pair valid per requester.
s_ready  out  2  sample-pair ready per requester.
s_data0  in  16  operand 0 samples; requester i in bits [8i+7:8i], signed 8-bit.
s_data1  in  16  operand 1 samples; same packing as s_data0.
r_data  out  16  signed result, shared bus; qualified by r_valid.
r_valid  out  2  result valid, only for the granted requester.
r_ready  in  2  result ready per requester.
done  out  2  one-cycle pulse at job completion.
err  out  2  one-cycle pulse on engine timeout.
eng_start  out  1  one-cycle pulse at the start of each job.
eng_ivalid  out  1  sample pair presented to the engine this cycle.
eng_idata0  out  8  operand 0 to the engine.
eng_idata1  out  8  operand 1 to the engine.
eng_done  in  1  engine finished computing; sampled only in WAIT.
eng_ovalid  in  1  engine result valid.
eng_odata  in  16  engine result.
eng_oready  out  1  result accepted by the downstream requester.

Behaviour:
- Reset is synchronous and active-low, and may assert in any state. Next edge: state=IDLE, all counters=0, RR pointer=0, and every output 0 (gnt, s_ready, r_valid, r_data, done, err, eng_start, eng_ivalid, eng_idata0/1, eng_oready). Engine results in flight are discarded.
- States: IDLE, GRANT, LOAD, WAIT, DRAIN, DONE, ABORT.
- IDLE: if req!=0, pick a requester. The requester at pointer ptr wins if it requests; otherwise the other one wins. Latch grant index g, set gnt[g], go to GRANT.
- GRANT: exactly one cycle. eng_start=1, load counter cleared, go to LOAD.
- LOAD: s_ready[g]=1; the other bit of s_ready is 0.
  - A transfer occurs when s_valid[g]&&s_ready[g].
  - On a transfer, eng_ivalid=1 and eng_idata0/1 carry lane g of s_data0/1 combinationally (zero added latency).
  - After the LEN-th transfer, s_ready drops the next cycle and the state moves to WAIT.
  - Stalls, i.e. s_valid=0, are unbounded.
- WAIT: a cycle counter increments each cycle.
  - If eng_done=1, go to DRAIN and clear the counter.
  - Otherwise, when the counter reaches TIMEOUT-1, go to ABORT.
- DRAIN: r_valid[g]=eng_ovalid, r_data=eng_odata, eng_oready=r_ready[g], all combinational.
  - Each handshake (eng_ovalid&&r_ready[g]) increments the result counter.
  - On the RES_CNT-th handshake, go to DONE.
  - r_data holds its last value when r_valid=0.
- DONE: done[g]=1 for one cycle, gnt cleared, ptr toggled to the other requester, go to IDLE.
- ABORT: err[g]=1 for one cycle, gnt cleared, ptr toggled, go to IDLE.
- Minimum job latency: 1 (GRANT) + LEN + wait + RES_CNT + 1 (DONE) cycles. Back-to-back jobs need one IDLE cycle between them.
- req deasserting mid-job is ignored; the job runs to completion.
- The non-granted requester sees s_ready=0 and r_valid=0 for the whole job.
- The arbiter never generates eng_ivalid outside LOAD or eng_oready outside DRAIN.
- Counters: 8-bit load counter, 8-bit result counter, $clog2(TIMEOUT)-bit wait counter; LEN ≤ 128.

Test Plan:
- Single job: req=01, 8 pairs 1..8 with s_valid held high → eng_start at cycle 1, 8 eng_ivalid cycles, 15 results forwarded with r_valid[0], one done[0] pulse, gnt back to 00.
- Contention: req=11 from reset → requester 0 served first, then requester 1 with one IDLE gap. Next simultaneous request → requester 0 wins again (pointer fairness).
- Backpressure: r_ready[0] toggling 1,0,1,0 during DRAIN → eng_oready tracks r_ready exactly, 15 handshakes total, no result lost or duplicated.
- Input stalls: s_valid[1] low for 3 cycles between pairs 4 and 5 → eng_ivalid low for exactly those 3 cycles, WAIT entered only after the 8th pair.
- Timeout: eng_done never asserted → err[g] pulses at WAIT cycle 256, no done, gnt cleared, ptr toggled.
- Reset mid-DRAIN after 5 results → next edge: all outputs 0, state IDLE. A subsequent req=10 is granted normally.

Source files
------------

// File: rtl/conv_job_arbiter_if.sv
// conv_job_arbiter_if: requester and convolution-engine signals of the job arbiter
interface conv_job_arbiter_if;
    logic [1:0]  req, gnt, s_valid, s_ready, r_valid, r_ready, done, err;
    logic [15:0] s_data0, s_data1, r_data, eng_odata;
    logic        eng_start, eng_ivalid, eng_done, eng_ovalid, eng_oready;
    logic [7:0]  eng_idata0, eng_idata1;
    modport master (
        input  req, s_valid, s_data0, s_data1, r_ready, eng_done, eng_ovalid, eng_odata,
        output gnt, s_ready, r_valid, r_data, done, err, eng_start, eng_ivalid, eng_idata0, eng_idata1, eng_oready
    );
    modport slave (
        output req, s_valid, s_data0, s_data1, r_ready, eng_done, eng_ovalid, eng_odata,
        input  gnt, s_ready, r_valid, r_data, done, err, eng_start, eng_ivalid, eng_idata0, eng_idata1, eng_oready
    );
endinterface

// File: rtl/conv_job_arbiter.sv
// conv_job_arbiter: round-robin sharing of one convolution engine between two requesters
module conv_job_arbiter #(
    parameter int LEN     = 8,
    parameter int TIMEOUT = 256
) (
    input logic               clk,
    input logic               reset,
    conv_job_arbiter_if.master bus_io
);
    localparam int RES_CNT = 2 * LEN - 1;
    localparam int WW      = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, GRANT, LOAD, WAIT, DRAIN, DONE, ABORT} state_t;

    state_t        state_q, state_d;
    logic          g_q, g_d, ptr_q, ptr_d;
    logic [7:0]    ld_cnt_q, ld_cnt_d, rs_cnt_q, rs_cnt_d;
    logic [WW-1:0] wt_cnt_q, wt_cnt_d;
    logic [15:0]   r_data_q, r_data_d;
    logic [1:0]    sel;
    logic          xfer, hs;

    // state, grant index, round-robin pointer, counters and held result word
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            g_q      <= 1'b0;
            ptr_q    <= 1'b0;
            ld_cnt_q <= '0;
            rs_cnt_q <= '0;
            wt_cnt_q <= '0;
            r_data_q <= '0;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            ptr_q    <= ptr_d;
            ld_cnt_q <= ld_cnt_d;
            rs_cnt_q <= rs_cnt_d;
            wt_cnt_q <= wt_cnt_d;
            r_data_q <= r_data_d;
        end
    end

    // outputs routed from the granted lane and next-state/counter logic
    always_comb begin
        sel                = g_q ? 2'b10 : 2'b01;
        xfer               = state_q == LOAD && bus_io.s_valid[g_q];
        hs                 = state_q == DRAIN && bus_io.eng_ovalid && bus_io.r_ready[g_q];
        r_data_d           = (state_q == DRAIN && bus_io.eng_ovalid) ? bus_io.eng_odata : r_data_q;
        bus_io.gnt         = state_q == IDLE ? 2'b00 : sel;
        bus_io.s_ready     = state_q == LOAD ? sel : 2'b00;
        bus_io.r_valid     = (state_q == DRAIN && bus_io.eng_ovalid) ? sel : 2'b00;
        bus_io.r_data      = r_data_d;
        bus_io.done        = state_q == DONE ? sel : 2'b00;
        bus_io.err         = state_q == ABORT ? sel : 2'b00;
        bus_io.eng_start   = state_q == GRANT;
        bus_io.eng_ivalid  = xfer;
        bus_io.eng_idata0  = xfer ? (g_q ? bus_io.s_data0[15:8] : bus_io.s_data0[7:0]) : 8'h00;
        bus_io.eng_idata1  = xfer ? (g_q ? bus_io.s_data1[15:8] : bus_io.s_data1[7:0]) : 8'h00;
        bus_io.eng_oready  = state_q == DRAIN && bus_io.r_ready[g_q];
        state_d            = state_q;
        g_d                = g_q;
        ptr_d              = ptr_q;
        ld_cnt_d           = ld_cnt_q;
        rs_cnt_d           = rs_cnt_q;
        wt_cnt_d           = wt_cnt_q;
        case (state_q)
            IDLE: if (|bus_io.req) begin
                g_d     = bus_io.req[ptr_q] ? ptr_q : ~ptr_q;
                state_d = GRANT;
            end
            GRANT: begin
                ld_cnt_d = '0;
                state_d  = LOAD;
            end
            LOAD: if (xfer) begin
                ld_cnt_d = ld_cnt_q + 8'd1;
                if (ld_cnt_q == 8'(LEN - 1)) begin
                    wt_cnt_d = '0;
                    state_d  = WAIT;
                end
            end
            WAIT: if (bus_io.eng_done) begin
                wt_cnt_d = '0;
                rs_cnt_d = '0;
                state_d  = DRAIN;
            end else if (wt_cnt_q == WW'(TIMEOUT - 1)) begin
                state_d  = ABORT;
            end else begin
                wt_cnt_d = wt_cnt_q + 1'b1;
            end
            DRAIN: if (hs) begin
                rs_cnt_d = rs_cnt_q + 8'd1;
                if (rs_cnt_q == 8'(RES_CNT - 1)) state_d = DONE;
            end
            DONE, ABORT: begin
                ptr_d   = ~g_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_conv_job_arbiter.sv
// tb_conv_job_arbiter: vector table for one full job plus directed multi-job sequences
module tb_conv_job_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    conv_job_arbiter_if bus ();
    conv_job_arbiter dut (.clk(clk), .reset(reset), .bus_io(bus));

    typedef struct packed {
        logic [1:0]  req, sv;
        logic [15:0] d0, d1;
        logic [1:0]  rr;
        logic        edone, eov;
        logic [15:0] eod;
    } ins_t;

    typedef struct packed {
        logic [1:0]  gnt, srdy, rv;
        logic [15:0] rdata;
        logic [1:0]  done, err;
        logic        start, ivalid;
        logic [7:0]  id0, id1;
        logic        ordy;
    } outs_t;

    typedef struct {
        ins_t  i;
        outs_t o;
    } vec_t;

    vec_t tab[29];

    function automatic logic [1:0] oh(input int w);
        return w != 0 ? 2'b10 : 2'b01;
    endfunction

    function automatic outs_t cur();
        outs_t o;
        o.gnt = bus.gnt; o.srdy = bus.s_ready; o.rv = bus.r_valid; o.rdata = bus.r_data;
        o.done = bus.done; o.err = bus.err; o.start = bus.eng_start; o.ivalid = bus.eng_ivalid;
        o.id0 = bus.eng_idata0; o.id1 = bus.eng_idata1; o.ordy = bus.eng_oready;
        return o;
    endfunction

    task automatic drive(input ins_t v);
        bus.req = v.req; bus.s_valid = v.sv; bus.s_data0 = v.d0; bus.s_data1 = v.d1;
        bus.r_ready = v.rr; bus.eng_done = v.edone; bus.eng_ovalid = v.eov; bus.eng_odata = v.eod;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic start_job(input int who);
        int n = 0;
        @(negedge clk);
        while (bus.gnt == 2'b00 && n < 10) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        chk("grant_gap", 64'(n), 64'd1);
        chk("grant", 64'(bus.gnt), 64'(oh(who)));
        chk("eng_start", 64'(bus.eng_start), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic load(input int who, input int stall_at, input int stall_len);
        int idle_iv = 0;
        for (int k = 0; k < 8; k++) begin
            if (k == stall_at) begin
                bus.s_valid = 2'b00;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    if (bus.eng_ivalid !== 1'b0) idle_iv++;
                    @(posedge clk); #1;
                end
            end
            bus.s_valid = oh(who);
            bus.s_data0 = who != 0 ? {8'(k + 1), 8'h11} : {8'h11, 8'(k + 1)};
            bus.s_data1 = who != 0 ? {8'(-k), 8'h22} : {8'h22, 8'(-k)};
            @(negedge clk);
            chk($sformatf("ivalid_pair%0d", k), 64'(bus.eng_ivalid), 64'd1);
            chk($sformatf("idata_pair%0d", k), 64'({bus.eng_idata0, bus.eng_idata1}), 64'({8'(k + 1), 8'(-k)}));
            @(posedge clk); #1;
        end
        bus.s_valid = 2'b00;
        if (stall_len > 0) chk("stall_ivalid", 64'(idle_iv), 64'd0);
        @(negedge clk);
        chk("wait_sready", 64'(bus.s_ready), 64'd0);
    endtask

    task automatic drain(input int who, input bit toggle, input int stop_after);
        int hs = 0;
        int bad = 0;
        int n = 0;
        bit rr;
        logic [15:0] od;
        bus.eng_done = 1'b1;
        @(posedge clk); #1;
        bus.eng_done = 1'b0;
        bus.eng_ovalid = 1'b1;
        while (n < 60) begin
            rr = !(toggle && (n % 2 == 1));
            od = 16'h4000 + 16'(hs * 7);
            bus.r_ready = rr ? 2'b11 : 2'b00;
            bus.eng_odata = od;
            @(negedge clk);
            if (bus.done != 2'b00 || bus.err != 2'b00) break;
            if (bus.eng_oready !== rr || bus.r_valid !== oh(who) || bus.r_data !== od) bad++;
            if (rr) hs++;
            n++;
            if (stop_after > 0 && hs == stop_after) break;
            @(posedge clk); #1;
        end
        chk("drain_track", 64'(bad), 64'd0);
        if (stop_after > 0) begin
            chk("partial_hs", 64'(hs), 64'(stop_after));
        end else begin
            chk("drain_hs", 64'(hs), 64'd15);
            chk("done_pulse", 64'({bus.done, bus.err}), 64'({oh(who), 2'b00}));
            chk("done_gnt", 64'(bus.gnt), 64'(oh(who)));
            bus.eng_ovalid = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        for (int r = 0; r < 29; r++) begin
            tab[r].i = '0;
            tab[r].o = '0;
            tab[r].i.req = 2'b01;
        end
        tab[1].o.gnt = 2'b01; tab[1].o.start = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tab[2 + k].i.sv = 2'b11;
            tab[2 + k].i.d0 = {8'hAA, 8'(k + 1)};
            tab[2 + k].i.d1 = {8'h55, 8'(8'hF0 + k)};
            tab[2 + k].o.gnt = 2'b01; tab[2 + k].o.srdy = 2'b01; tab[2 + k].o.ivalid = 1'b1;
            tab[2 + k].o.id0 = 8'(k + 1); tab[2 + k].o.id1 = 8'(8'hF0 + k);
        end
        tab[10].o.gnt = 2'b01;
        tab[11].o.gnt = 2'b01; tab[11].i.edone = 1'b1;
        for (int j = 0; j < 15; j++) begin
            tab[12 + j].i.rr = 2'b11; tab[12 + j].i.eov = 1'b1; tab[12 + j].i.eod = 16'h8000 + 16'(j);
            tab[12 + j].o.gnt = 2'b01; tab[12 + j].o.rv = 2'b01; tab[12 + j].o.rdata = 16'h8000 + 16'(j);
            tab[12 + j].o.ordy = 1'b1;
        end
        tab[27].o.gnt = 2'b01; tab[27].o.done = 2'b01; tab[27].o.rdata = 16'h800E;
        tab[28].i.req = 2'b00; tab[28].o.rdata = 16'h800E;

        drive('0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int r = 0; r < 29; r++) begin
            drive(tab[r].i);
            @(negedge clk);
            chk($sformatf("row%0d", r), 64'(cur()), 64'(tab[r].o));
            @(posedge clk); #1;
        end

        drive('0);
        do_reset();
        bus.req = 2'b11;
        start_job(0); load(0, -1, 0); drain(0, 1'b0, 0);
        bus.req = 2'b10;
        start_job(1); load(1, 4, 3); drain(1, 1'b0, 0);
        bus.req = 2'b11;
        start_job(0); load(0, -1, 0); drain(0, 1'b1, 0);

        start_job(1); load(1, -1, 0);
        n = 1;
        while (bus.err == 2'b00 && n < 300) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        chk("timeout_cycle", 64'(n), 64'd257);
        chk("timeout_err", 64'({bus.err, bus.done, bus.gnt}), 64'({2'b10, 2'b00, 2'b10}));
        @(posedge clk); #1;

        start_job(0); load(0, -1, 0); drain(0, 1'b0, 5);
        @(posedge clk); #1;
        bus.req = 2'b00; bus.s_valid = 2'b11; bus.r_ready = 2'b11;
        do_reset();
        @(negedge clk);
        chk("reset_outputs", 64'(cur()), 64'd0);
        @(posedge clk); #1;
        bus.s_valid = 2'b00; bus.eng_ovalid = 1'b0;
        bus.req = 2'b10;
        start_job(1); load(1, -1, 0); drain(1, 1'b0, 0);
        bus.req = 2'b00;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
